// File: rtl/lsu_xbar_if.sv
// rtl/lsu_xbar_if.sv - AXI4-Lite bus between lsu_xbar (master) and the system interconnect (slave)
interface lsu_xbar_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/lsu_xbar.sv
// rtl/lsu_xbar.sv - LSU address crossbar: CLINT window to the CLINT opcode bus, everything else to AXI4-Lite
// Optional difftest_skip_o output when LSU_XBAR_DIFFTEST_SKIP_EN is defined.
module lsu_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_wen_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] clint_addr_o,
    output logic [1:0]  clint_opcode_o,
    output logic [31:0] clint_wdata_o,
    output logic [3:0]  clint_wstrb_o,
    input  logic [31:0] clint_rdata_i,
    input  logic        clint_resp_i,
`ifdef LSU_XBAR_DIFFTEST_SKIP_EN
    output logic        difftest_skip_o,
`endif
    lsu_xbar_if.master  axi
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLINT_RD, S_AR, S_R, S_AW_W, S_B, S_ERR
    } state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        skip_q;
    logic [1:0]  clint_opcode_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;

    logic req_is_clint;
    logic aw_fire;
    logic w_fire;
    logic aw_done_d;
    logic w_done_d;
    logic unused_clint_resp;

    assign req_is_clint = (req_addr_i & CLINT_MASK) == (CLINT_BASE & CLINT_MASK);
    assign aw_fire      = awvalid_q && axi.awready;
    assign w_fire       = wvalid_q && axi.wready;
    assign aw_done_d    = aw_done_q || aw_fire;
    assign w_done_d     = w_done_q || w_fire;
    // The CLINT response flag is sticky after the first access, so it carries no timing information.
    assign unused_clint_resp = clint_resp_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            req_ready_q    <= 1'b1;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            wstrb_q        <= 4'h0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0;
            resp_err_q     <= 1'b0;
            skip_q         <= 1'b0;
            clint_opcode_q <= 2'd0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
        end else begin
            resp_valid_q   <= 1'b0;
            skip_q         <= 1'b0;
            clint_opcode_q <= 2'd0;
            // Ready returns only in the cycle after the response pulse.
            if (resp_valid_q) begin
                req_ready_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        wstrb_q     <= req_wstrb_i;
                        if (req_is_clint && req_wen_i) begin
                            state_q      <= S_ERR;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            skip_q       <= 1'b1;
                        end else if (req_is_clint) begin
                            state_q        <= S_CLINT_RD;
                            clint_opcode_q <= 2'd1;
                        end else if (req_wen_i) begin
                            state_q   <= S_AW_W;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= S_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_CLINT_RD: begin
                    state_q      <= S_IDLE;
                    resp_rdata_q <= clint_rdata_i;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    skip_q       <= 1'b1;
                end
                S_AR: begin
                    if (axi.arready) begin
                        state_q   <= S_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                S_R: begin
                    if (axi.rvalid) begin
                        state_q      <= S_IDLE;
                        rready_q     <= 1'b0;
                        resp_rdata_q <= axi.rdata;
                        resp_err_q   <= (axi.rresp != 2'b00);
                        resp_valid_q <= 1'b1;
                    end
                end
                S_AW_W: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                    end
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        state_q  <= S_B;
                        bready_q <= 1'b1;
                    end
                end
                S_B: begin
                    if (axi.bvalid) begin
                        state_q      <= S_IDLE;
                        bready_q     <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= (axi.bresp != 2'b00);
                        resp_valid_q <= 1'b1;
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_err_o     = resp_err_q;
    assign clint_addr_o   = addr_q;
    assign clint_opcode_o = clint_opcode_q;
    assign clint_wdata_o  = wdata_q;
    assign clint_wstrb_o  = wstrb_q;
`ifdef LSU_XBAR_DIFFTEST_SKIP_EN
    assign difftest_skip_o = skip_q & resp_valid_q;
`else
    logic unused_skip;
    assign unused_skip = skip_q;
`endif

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.rready  = rready_q;
endmodule

// File: doc/lsu_xbar.md
Name: lsu_xbar

Overview:
Address-decoding crossbar between the LSU memory port and the system slaves. Each LSU request goes to one of two places. Addresses in the CLINT window go to the CLINT timer slave over its simple opcode bus. All other addresses go to a single AXI4-Lite master port. Exactly one transaction is outstanding at a time, and the response returns to the LSU as a single-cycle pulse.

Parameters:
CLINT_BASE, 32'h0200_0000, base address of the CLINT window
CLINT_MASK, 32'hFFFF_0000, address bits compared against CLINT_BASE

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  1  LSU request valid
req_ready  out  1  xbar can accept a request
req_addr  in  32  byte address
req_wen  in  1  1 = write, 0 = read
req_wdata  in  32  write data
req_wstrb  in  4  byte strobes
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  read data, valid with resp_valid
resp_err  out  1  access error, valid with resp_valid
clint_addr  out  32  CLINT address
clint_opcode  out  2  0 = idle, 1 = read, 2 = write
clint_wdata  out  32  CLINT write data
clint_wstrb  out  4  CLINT strobes
clint_rdata  in  32  CLINT read data
clint_resp  in  1  CLINT response flag (sticky; not used as a handshake)
awvalid/awready/awaddr  out/in/out  1/1/32  AXI write address channel
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  AXI write data channel
bvalid/bready/bresp  in/out/in  1/1/2  AXI write response channel
arvalid/arready/araddr  out/in/out  1/1/32  AXI read address channel
rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  AXI read data channel

Behaviour:
- Reset values: all valid and ready outputs are 0, except req_ready = 1. clint_opcode = 0. All data and address outputs are 0. State is IDLE.
- Acceptance: a request is accepted on req_valid && req_ready. On acceptance, addr, wen, wdata and wstrb are latched. req_ready = 1 only in IDLE.
- Decode: is_clint = ((addr & CLINT_MASK) == (CLINT_BASE & CLINT_MASK)).
- States: IDLE, CLINT_RD, AR, R, AW_W, B, ERR.
- IDLE transitions:
  - CLINT read goes to CLINT_RD.
  - CLINT write goes to ERR, because the CLINT is read-only.
  - AXI read goes to AR.
  - AXI write goes to AW_W.
- CLINT_RD:
  - clint_opcode = 1 for exactly this one cycle; clint_addr holds the latched address.
  - resp_rdata = clint_rdata is sampled this cycle, and resp_valid pulses on the next edge.
  - Latency is 2 cycles from acceptance to resp_valid.
  - clint_resp is ignored: it stays high after the first access, so it cannot serve as a handshake.
- AR:
  - arvalid = 1, araddr = latched address.
  - arvalid stays high, with araddr stable, until arready; then go to R.
- R:
  - rready = 1.
  - On rvalid, register rdata, set resp_err = (rresp != 0), pulse resp_valid, and return to IDLE.
- AW_W:
  - awvalid and wvalid both assert on entry.
  - Each channel drops independently once its own handshake completes; per-channel "done" flags track this.
  - Go to B when both channels are done, which includes the case where both complete in the same cycle.
- B:
  - bready = 1.
  - On bvalid, set resp_err = (bresp != 0), pulse resp_valid, and return to IDLE.
- ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0; then return to IDLE.
- Response pulse: resp_valid lasts exactly 1 cycle. The LSU cannot backpressure it.
- Back-to-back requests: the next request can be accepted in the cycle after resp_valid, when the xbar is back in IDLE.
- req_valid while busy: ignored, with no buffering.
- Reset mid-transaction: next state is IDLE, and all valids, readies and clint_opcode drop in the cycle after the reset edge. The outstanding AXI transaction is abandoned.
- AXI output stability: AXI valid outputs are registered. Address and data outputs do not change while their valid is high and ready is low.

Optional Feature:
- Macro: LSU_XBAR_DIFFTEST_SKIP_EN.
- When defined:
  - An extra output port is added: difftest_skip, out, 1.
  - It equals 1 in the same cycle as resp_valid whenever the completed access decoded to the CLINT window (CLINT_RD or ERR-from-CLINT).
  - This tells the simulator to skip reference-model comparison.
- When undefined: the port is absent and the rest of the behaviour is identical.

Test Plan:
- CLINT read of 0x0200_0000 accepted at cycle 20 after reset release → resp_valid at acceptance+2, resp_rdata equals CLINT low counter value sampled in CLINT_RD, resp_err = 0.
- CLINT read of 0x0200_0004 shortly after reset → resp_rdata = 0x0000_0000 (high word), clint_opcode = 1 for exactly 1 cycle.
- CLINT write to 0x0200_0000 with wdata 0x1234_5678 → clint_opcode never 2, resp_valid with resp_err = 1 one cycle after acceptance.
- AXI read of 0x8000_0000 with arready delayed 3 cycles, then rvalid with rdata 0xDEAD_BEEF, rresp 0 → araddr stable during the wait, resp_rdata = 0xDEAD_BEEF, resp_err = 0.
- AXI write of 0x8000_0010 with wstrb 4'b0011, awready 2 cycles before wready, bresp 2'b10 → awvalid drops after its handshake while wvalid stays high until its own; resp_err = 1.
- reset asserted while in R state → next cycle req_ready = 1 and arvalid = rready = resp_valid = 0; a subsequent CLINT read completes normally.
